// File: rtl/quad_updown_decoder.sv
// Quadrature (A/B) decoder with x4 edge decoding driving a wrapping up/down
// counter; mode=1 means the last applied step was downward.
module quad_updown_decoder #(
  parameter int WIDTH       = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             en,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QB,
  output logic             mode,
  output logic             step,
  output logic             err
);

  localparam logic [1:0] DIR_NONE = 2'd0;
  localparam logic [1:0] DIR_UP   = 2'd1;
  localparam logic [1:0] DIR_DOWN = 2'd2;
  localparam logic [1:0] DIR_ILL  = 2'd3;

  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  // Gray-code transition table: A leading B counts up, B leading A counts down,
  // and a simultaneous change of both phases cannot be attributed to either.
  function automatic logic [1:0] classify(input logic [1:0] prv, input logic [1:0] cur);
    logic [1:0] dir;
    dir = DIR_NONE;
    case ({prv, cur})
      4'b0010, 4'b1011, 4'b1101, 4'b0100: dir = DIR_UP;
      4'b0001, 4'b0111, 4'b1110, 4'b1000: dir = DIR_DOWN;
      4'b0011, 4'b1100, 4'b1001, 4'b0110: dir = DIR_ILL;
      default:                            dir = DIR_NONE;
    endcase
    return dir;
  endfunction

  logic [SYNC_STAGES-1:0] a_sync_q, a_sync_d;
  logic [SYNC_STAGES-1:0] b_sync_q, b_sync_d;
  logic [1:0]             prev_q, prev_d;
  logic                   primed_q, primed_d;
  logic [WIDTH-1:0]       cnt_q, cnt_d;
  logic                   mode_q, mode_d;
  logic                   step_q, step_d;
  logic                   err_q, err_d;
  logic [1:0]             cur;
  logic [1:0]             dir;

  assign a_sync_d = {a_sync_q[SYNC_STAGES-2:0], a_in};
  assign b_sync_d = {b_sync_q[SYNC_STAGES-2:0], b_in};
  assign cur      = {a_sync_q[SYNC_STAGES-1], b_sync_q[SYNC_STAGES-1]};
  assign dir      = classify(prev_q, cur);

  always_comb begin
    prev_d   = cur;
    primed_d = 1'b1;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    step_d   = 1'b0;
    err_d    = 1'b0;
    // The first clock after reset only captures a reference phase state.
    if (primed_q) begin
      case (dir)
        DIR_UP: begin
          if (en) begin
            cnt_d  = cnt_q + CNT_ONE;
            mode_d = 1'b0;
            step_d = 1'b1;
          end
        end
        DIR_DOWN: begin
          if (en) begin
            cnt_d  = cnt_q - CNT_ONE;
            mode_d = 1'b1;
            step_d = 1'b1;
          end
        end
        DIR_ILL: err_d = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      a_sync_q <= '0;
      b_sync_q <= '0;
      prev_q   <= 2'b00;
      primed_q <= 1'b0;
      cnt_q    <= '0;
      mode_q   <= 1'b0;
      step_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      a_sync_q <= a_sync_d;
      b_sync_q <= b_sync_d;
      prev_q   <= prev_d;
      primed_q <= primed_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      step_q   <= step_d;
      err_q    <= err_d;
    end
  end

  assign Q    = cnt_q;
  assign QB   = ~cnt_q;
  assign mode = mode_q;
  assign step = step_q;
  assign err  = err_q;

endmodule

// File: tb/tb_quad_updown_decoder.sv
// Directed bench for quad_updown_decoder: per-cycle vector table plus
// hand-written reset/priming sequences.
module tb_quad_updown_decoder;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       a_in = 1'b0;
  logic       b_in = 1'b0;
  logic       en = 1'b1;
  logic [2:0] Q, QB;
  logic       mode, step, err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       a;
    logic       b;
    logic       en;
    logic [2:0] q;
    logic       mode;
    logic       step;
    logic       err;
  } vec_t;

  vec_t vq[$];

  quad_updown_decoder #(.WIDTH(3), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .clr (clr),
    .a_in(a_in),
    .b_in(b_in),
    .en  (en),
    .Q   (Q),
    .QB  (QB),
    .mode(mode),
    .step(step),
    .err (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic a, input logic b, input logic e, input logic [2:0] q,
                     input logic m, input logic s, input logic er);
    vec_t v;
    v.a = a; v.b = b; v.en = e; v.q = q; v.mode = m; v.step = s; v.err = er;
    vq.push_back(v);
  endtask

  initial begin
    // Row i is driven before edge i+1 after release; its expected outputs come
    // from the phase transition sampled two rows earlier (row 0 is priming).
    add(0,0,1, 3'd0,0,0,0);  // 0  priming
    add(1,0,1, 3'd0,0,0,0);  // 1
    add(1,0,1, 3'd0,0,0,0);  // 2
    add(1,0,1, 3'd1,0,1,0);  // 3  00->10 up
    add(1,1,1, 3'd1,0,0,0);  // 4
    add(1,1,1, 3'd1,0,0,0);  // 5
    add(0,1,1, 3'd2,0,1,0);  // 6  10->11 up
    add(0,1,1, 3'd2,0,0,0);  // 7
    add(0,0,1, 3'd3,0,1,0);  // 8  11->01 up
    add(0,0,1, 3'd3,0,0,0);  // 9
    add(0,0,1, 3'd4,0,1,0);  // 10 01->00 up
    add(0,0,1, 3'd4,0,0,0);  // 11
    add(0,1,1, 3'd4,0,0,0);  // 12
    add(1,1,1, 3'd4,0,0,0);  // 13
    add(1,0,1, 3'd3,1,1,0);  // 14 00->01 down
    add(0,0,1, 3'd2,1,1,0);  // 15 01->11 down
    add(0,1,1, 3'd1,1,1,0);  // 16 11->10 down
    add(1,1,1, 3'd0,1,1,0);  // 17 10->00 down
    add(1,1,1, 3'd7,1,1,0);  // 18 00->01 down, wrap 0->7
    add(1,1,1, 3'd6,1,1,0);  // 19 01->11 down
    add(1,1,1, 3'd6,1,0,0);  // 20
    add(0,0,1, 3'd6,1,0,0);  // 21
    add(0,0,1, 3'd6,1,0,0);  // 22
    add(0,0,1, 3'd6,1,0,1);  // 23 11->00 illegal
    add(1,0,0, 3'd6,1,0,0);  // 24
    add(1,1,0, 3'd6,1,0,0);  // 25
    add(0,1,0, 3'd6,1,0,0);  // 26 00->10 with en=0
    add(0,0,0, 3'd6,1,0,0);  // 27 10->11 with en=0
    add(0,0,0, 3'd6,1,0,0);  // 28 11->01 with en=0
    add(0,0,1, 3'd7,0,1,0);  // 29 01->00 with en=1
    add(0,0,1, 3'd7,0,0,0);  // 30
    add(1,0,1, 3'd7,0,0,0);  // 31
    add(1,0,1, 3'd7,0,0,0);  // 32
    add(1,0,1, 3'd0,0,1,0);  // 33 00->10 up, wrap 7->0
    add(1,0,1, 3'd0,0,0,0);  // 34

    // Reset held with phases low.
    #3 clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("rst_Q[%0d]", i), Q, 0);
      check($sformatf("rst_QB[%0d]", i), QB, 7);
      check($sformatf("rst_mode[%0d]", i), mode, 0);
      check($sformatf("rst_step[%0d]", i), step, 0);
      check($sformatf("rst_err[%0d]", i), err, 0);
    end

    // Release at a negedge together with row 0.
    for (int i = 0; i < vq.size(); i++) begin
      a_in = vq[i].a;
      b_in = vq[i].b;
      en   = vq[i].en;
      if (i == 0) clr = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("Q[%0d]", i), Q, vq[i].q);
      check($sformatf("QB[%0d]", i), QB, 3'(~vq[i].q));
      check($sformatf("mode[%0d]", i), mode, vq[i].mode);
      check($sformatf("step[%0d]", i), step, vq[i].step);
      check($sformatf("err[%0d]", i), err, vq[i].err);
    end

    // 10->00 down step from 0, then an asynchronous clear between edges.
    a_in = 1'b0; b_in = 1'b0; en = 1'b1;
    repeat (4) @(negedge clk);
    check("pre_clr_Q", Q, 7);
    check("pre_clr_mode", mode, 1);
    #2 clr = 1'b0;
    #1;
    check("async_clr_Q", Q, 0);
    check("async_clr_QB", QB, 7);
    check("async_clr_mode", mode, 0);
    check("async_clr_step", step, 0);

    // Phases high during reset, then release: priming must not count.
    a_in = 1'b1; b_in = 1'b1;
    repeat (3) @(negedge clk);
    clr = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("prime11_step[%0d]", i), step, 0);
      check($sformatf("prime11_Q[%0d]", i), Q, 0);
      check($sformatf("prime11_mode[%0d]", i), mode, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
